spi_cfg: RTL and testbench
==========================

# spi_cfg

Write-only SPI master that configures on-board peripherals (ADC, DAC, clock generator, etc.) from a 32-bit AXI4-Stream word. An 8-bit command selects one of four active-low chip selects and a frame length of 1–4 bytes. It sits between the processor-side configuration registers/FIFO and the board SPI pins. It only transmits and has no MISO path.

## Interface
- `CLK_DIV`, default 4: SCLK half-period in `aclk` cycles, minimum 1. SCLK = aclk / (2·CLK_DIV).
- `aclk`  in  1  system clock; all logic is on the rising edge.
- `areset`  in  1  reset, synchronous and active-high.
- `s_axis_tdata`  in  32  frame data, left-justified; bit 31 is sent first.
- `s_axis_tvalid`  in  1  a frame is available.
- `s_axis_tready`  out  1  block is idle and accepts a frame.
- `cmd`  in  8  frame control, sampled at acceptance:
  - [1:0] chip-select index.
  - [3:2] byte count minus 1.
  - [7:4] reserved and ignored.
- `cs`  out  4  active-low chip selects; at most one is low at any time.
- `sclk`  out  1  SPI clock, idle low.
- `sdi`  out  1  serial data to the slaves, MSB first.

## Operation
- SPI mode 0: the slave samples `sdi` on the rising edge of `sclk`. `sdi` changes only while `sclk` is low.
- Acceptance: a frame is accepted on a rising edge where `s_axis_tvalid & s_axis_tready` is 1. On that edge, latch `s_axis_tdata` into the shift register, `cmd[1:0]` as the CS index, and N = 8·(`cmd[3:2]`+1) bits.
- Inputs are ignored while busy. Changes to `cmd` or `tdata` mid-frame have no effect.
- State machine:
  - IDLE: `tready`=1, `cs`=4'hF, `sclk`=0, `sdi`=0. On accept, go to LOW.
  - LOW: the selected `cs` bit is 0, `sclk`=0, `sdi`=current bit. Lasts CLK_DIV cycles, then go to HIGH.
  - HIGH: `sclk`=1, lasts CLK_DIV cycles. Then:
    - If bits remain, shift left and go to LOW.
    - After bit N, go to HOLD.
  - HOLD: `sclk`=0, `cs` still asserted, lasts CLK_DIV cycles, then go to GAP.
  - GAP: `cs`=4'hF, `tready`=0, lasts CLK_DIV cycles, then go to IDLE.
- Bits sent are `tdata[31:32-N]`. Remaining low bits are discarded.
- Back-to-back frames: with `tvalid` held high, the next frame is accepted on the first IDLE cycle. There is always a minimum CS-high gap of CLK_DIV cycles plus one IDLE cycle.
- Reset, including mid-frame, forces IDLE on the next edge: `cs`=4'hF, `sclk`=0, `sdi`=0, `tready`=1. A partial frame is abandoned and not resumed.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- Accept on edge t0:
  - From t0+1: `cs` asserted, `sdi`=bit 31, `tready`=0.
  - First `sclk` rise at t0+1+CLK_DIV.
- Busy duration is 2·N·CLK_DIV + 2·CLK_DIV cycles; `tready` returns high at t0+1 plus that value.
- `cs` low duration is 2·N·CLK_DIV + CLK_DIV cycles.
- Exactly N `sclk` pulses per frame, each high CLK_DIV cycles and low CLK_DIV cycles.
- Counters: a half-period counter of width clog2(CLK_DIV)+1 and a 6-bit bit counter; no wrap beyond 32.

## Structure
- Package `spi_cfg_pkg`:
  - State enum (IDLE, LOW, HIGH, HOLD, GAP).
  - `cmd` field positions.
  - N_CS = 4.
  - DATA_W = 32.
- Optional sub-module `spi_cfg_tick`: half-period counter producing a one-cycle `tick` every CLK_DIV cycles while busy, cleared on accept.
- Everything else (FSM, shift register, bit counter, CS decode) lives in `spi_cfg`.

## Test plan
All scenarios use CLK_DIV=4.
- Reset held, then released → `cs`=4'hF, `sclk`=0, `tready`=1. No activity while `tvalid`=0.
- `cmd`=0x0A, `tdata`=0xC001E801, `tvalid` pulsed 10 cycles:
  - `cs`=4'b1011 for 196 cycles.
  - 24 `sclk` pulses; bits sampled on rising edges = 0xC001E8.
  - Exactly one frame; `tready` low 200 cycles.
- `cmd`=0x0A, `tdata`=0xE8030001, `tvalid` held high → repeated identical frames (0xE80300 on `cs[2]`), one accepted every 201 cycles, `cs` high ≥4 cycles between frames.
- `cmd`=0x0C, `tdata`=0xA5A5_0F0F:
  - `cs[0]` low, 32 pulses, data 0xA5A50F0F.
  - `cmd`=0xF1 with `tdata`=0x81xxxxxx → `cs[1]` low, 8 pulses, data 0x81 (upper `cmd` bits ignored).
- `areset` asserted midway through a 24-bit frame → next cycle `cs`=4'hF, `sclk`=0, `tready`=1; a new frame afterwards transmits correctly from bit 31.
- `tdata`/`cmd` changed during a busy frame → transmitted bits and CS unchanged from the values latched at acceptance.

Source files
------------

// File: rtl/spi_cfg_pkg.sv
// rtl/spi_cfg_pkg.sv - shared types and constants for the SPI configuration master
package spi_cfg_pkg;

    localparam int N_CS   = 4;
    localparam int DATA_W = 32;

    // Command byte field positions
    localparam int CMD_CS_LSB  = 0;
    localparam int CMD_CS_W    = 2;
    localparam int CMD_LEN_LSB = 2;
    localparam int CMD_LEN_W   = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_HOLD,
        ST_GAP
    } state_t;

    // Bits in a frame: 8 * (byte count minus one + 1)
    function automatic logic [5:0] frame_bits(input logic [CMD_LEN_W-1:0] len_m1);
        return {1'b0, len_m1, 3'b000} + 6'd8;
    endfunction

endpackage

// File: rtl/spi_cfg_tick.sv
// rtl/spi_cfg_tick.sv - half-period tick generator for the SPI clock
module spi_cfg_tick
    import spi_cfg_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic busy_i,
    output logic tick_o
);

    localparam int CW = $clog2(CLK_DIV) + 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // A tick marks the last cycle of each half-period
    assign tick_o = busy_i && (cnt_q == CW'(CLK_DIV - 1));

    // Next count: restart on accept, on tick, or while idle
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !busy_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Half-period counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_cfg.sv
// rtl/spi_cfg.sv - write-only SPI mode-0 master for board peripheral configuration
module spi_cfg
    import spi_cfg_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [7:0]        cmd,
    output logic [N_CS-1:0]   cs,
    output logic              sclk,
    output logic              sdi
);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [5:0]          bits_q, bits_d;
    logic [CMD_CS_W-1:0] cs_idx_q, cs_idx_d;
    logic [N_CS-1:0]     cs_q, cs_d;
    logic                sclk_q, sclk_d;
    logic                sdi_q, sdi_d;
    logic                tready_q, tready_d;
    logic                accept;
    logic                tick;

    // Reserved command bits carry no meaning
    logic unused_cmd;
    assign unused_cmd = ^cmd[7:4];

    assign accept = tready_q && s_axis_tvalid;

    spi_cfg_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_i   (aclk),
        .rst_i   (areset),
        .clear_i (accept),
        .busy_i  (state_q != ST_IDLE),
        .tick_o  (tick)
    );

    // Next state, datapath and the pin values for the next cycle
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bits_d   = bits_q;
        cs_idx_d = cs_idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shift_d  = s_axis_tdata;
                    bits_d   = frame_bits(cmd[CMD_LEN_LSB +: CMD_LEN_W]);
                    cs_idx_d = cmd[CMD_CS_LSB +: CMD_CS_W];
                    state_d  = ST_LOW;
                end
            end
            ST_LOW: begin
                if (tick) state_d = ST_HIGH;
            end
            ST_HIGH: begin
                if (tick) begin
                    if (bits_q == 6'd1) begin
                        state_d = ST_HOLD;
                    end else begin
                        shift_d = {shift_q[DATA_W-2:0], 1'b0};
                        bits_d  = bits_q - 6'd1;
                        state_d = ST_LOW;
                    end
                end
            end
            ST_HOLD: begin
                if (tick) state_d = ST_GAP;
            end
            ST_GAP: begin
                if (tick) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Pins are decoded from the next state so they register in step with it
        cs_d     = '1;
        sclk_d   = 1'b0;
        sdi_d    = 1'b0;
        tready_d = (state_d == ST_IDLE);
        if (state_d == ST_LOW || state_d == ST_HIGH || state_d == ST_HOLD) begin
            cs_d = ~(N_CS'(1) << cs_idx_d);
        end
        if (state_d == ST_HIGH) begin
            sclk_d = 1'b1;
        end
        if (state_d == ST_LOW || state_d == ST_HIGH) begin
            sdi_d = shift_d[DATA_W-1];
        end
    end

    // State, datapath and output registers
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            bits_q   <= '0;
            cs_idx_q <= '0;
            cs_q     <= '1;
            sclk_q   <= 1'b0;
            sdi_q    <= 1'b0;
            tready_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bits_q   <= bits_d;
            cs_idx_q <= cs_idx_d;
            cs_q     <= cs_d;
            sclk_q   <= sclk_d;
            sdi_q    <= sdi_d;
            tready_q <= tready_d;
        end
    end

    assign cs            = cs_q;
    assign sclk          = sclk_q;
    assign sdi           = sdi_q;
    assign s_axis_tready = tready_q;

endmodule

// File: tb/tb_spi_cfg.sv
// tb/tb_spi_cfg.sv - directed self-checking bench for spi_cfg
module tb_spi_cfg;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [7:0]  cmd = '0;
    logic [3:0]  cs;
    logic        sclk;
    logic        sdi;

    int checks = 0;
    int errors = 0;

    spi_cfg #(.CLK_DIV(4)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .cmd           (cmd),
        .cs            (cs),
        .sclk          (sclk),
        .sdi           (sdi)
    );

    always #5 aclk = ~aclk;

    // Pin monitor: reconstructs each frame seen on cs/sclk/sdi
    int          cyc = 0;
    logic        prev_sclk = 1'b0;
    logic        prev_sdi = 1'b0;
    logic [3:0]  prev_cs = 4'hF;
    logic        prev_rdy = 1'b1;
    logic [31:0] cap = '0;
    int          pulses = 0;
    int          cs_cnt = 0;
    int          gap_cnt = 0;
    int          rdy_low = 0;
    int          frames_done = 0;
    logic [31:0] last_bits = '0;
    int          last_pulses = 0;
    int          last_cs_low = 0;
    logic [3:0]  last_cs = 4'hF;
    int          last_start = 0;
    int          last_period = 0;
    int          last_gap = 0;
    int          last_rdy_low = 0;
    int          inv_viol = 0;

    always @(negedge aclk) begin
        cyc       <= cyc + 1;
        prev_sclk <= sclk;
        prev_sdi  <= sdi;
        prev_cs   <= cs;
        prev_rdy  <= s_axis_tready;
        if (!(cs inside {4'hF, 4'hE, 4'hD, 4'hB, 4'h7}) ||
            (prev_sclk && sclk && (sdi != prev_sdi)) ||
            (sclk && cs == 4'hF))
            inv_viol <= inv_viol + 1;
        if (prev_cs == 4'hF && cs != 4'hF) begin
            cap         <= '0;
            pulses      <= 0;
            cs_cnt      <= 1;
            last_gap    <= gap_cnt;
            last_period <= cyc - last_start;
            last_start  <= cyc;
        end else if (cs != 4'hF) begin
            cs_cnt <= cs_cnt + 1;
            if (!prev_sclk && sclk) begin
                pulses <= pulses + 1;
                cap    <= {cap[30:0], sdi};
            end
        end else if (prev_cs != 4'hF) begin
            last_bits   <= cap;
            last_pulses <= pulses;
            last_cs_low <= cs_cnt;
            last_cs     <= prev_cs;
            frames_done <= frames_done + 1;
            gap_cnt     <= 1;
        end else begin
            gap_cnt <= gap_cnt + 1;
        end
        if (!s_axis_tready) begin
            rdy_low <= rdy_low + 1;
        end else if (!prev_rdy) begin
            last_rdy_low <= rdy_low;
            rdy_low      <= 0;
        end
    end

    task automatic step();
        @(negedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_frames(input string tag, input int target, input int budget);
        int n = 0;
        while (frames_done < target && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(frames_done >= target), 32'd1);
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n = 0;
        while (!s_axis_tready && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(s_axis_tready), 32'd1);
    endtask

    task automatic pulse_frame(input logic [7:0] c, input logic [31:0] d);
        cmd           = c;
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        step();
        s_axis_tvalid = 1'b0;
    endtask

    initial begin
        int base;

        // Reset held, then released
        repeat (3) step();
        areset = 1'b0;
        step();
        check("rst_cs",     32'(cs), 32'hF);
        check("rst_sclk",   32'(sclk), 32'd0);
        check("rst_sdi",    32'(sdi), 32'd0);
        check("rst_tready", 32'(s_axis_tready), 32'd1);
        base = frames_done;
        repeat (20) step();
        check("idle_frames", 32'(frames_done), 32'(base));
        check("idle_cs",     32'(cs), 32'hF);

        // 24-bit frame on cs[2], tvalid held for 10 cycles
        base = frames_done;
        cmd = 8'h0A; s_axis_tdata = 32'hC001E801; s_axis_tvalid = 1'b1;
        repeat (10) step();
        s_axis_tvalid = 1'b0;
        wait_frames("f24_timeout", base + 1, 400);
        check("f24_bits",   last_bits, 32'h00C001E8);
        check("f24_pulses", 32'(last_pulses), 32'd24);
        check("f24_cs_low", 32'(last_cs_low), 32'd196);
        check("f24_cs",     32'(last_cs), 32'hB);
        wait_ready("f24_ready_timeout", 50);
        check("f24_rdy_low", 32'(last_rdy_low), 32'd200);
        repeat (100) step();
        check("f24_once", 32'(frames_done), 32'(base + 1));

        // Back-to-back frames with tvalid held high
        base = frames_done;
        cmd = 8'h0A; s_axis_tdata = 32'hE8030001; s_axis_tvalid = 1'b1;
        wait_frames("b2b_timeout", base + 3, 1000);
        s_axis_tvalid = 1'b0;
        check("b2b_bits",   last_bits, 32'h00E80300);
        check("b2b_pulses", 32'(last_pulses), 32'd24);
        check("b2b_cs",     32'(last_cs), 32'hB);
        check("b2b_period", 32'(last_period), 32'd201);
        check("b2b_gap",    32'(last_gap), 32'd5);
        wait_ready("b2b_ready_timeout", 50);
        repeat (300) step();
        check("b2b_stop", 32'(frames_done), 32'(base + 3));

        // 32-bit frame on cs[0]
        base = frames_done;
        pulse_frame(8'h0C, 32'hA5A50F0F);
        wait_frames("f32_timeout", base + 1, 400);
        check("f32_bits",   last_bits, 32'hA5A50F0F);
        check("f32_pulses", 32'(last_pulses), 32'd32);
        check("f32_cs_low", 32'(last_cs_low), 32'd260);
        check("f32_cs",     32'(last_cs), 32'hE);
        wait_ready("f32_ready_timeout", 50);

        // 8-bit frame on cs[1], reserved cmd bits set
        base = frames_done;
        pulse_frame(8'hF1, 32'h81234567);
        wait_frames("f8_timeout", base + 1, 200);
        check("f8_bits",   last_bits, 32'h00000081);
        check("f8_pulses", 32'(last_pulses), 32'd8);
        check("f8_cs_low", 32'(last_cs_low), 32'd68);
        check("f8_cs",     32'(last_cs), 32'hD);
        wait_ready("f8_ready_timeout", 50);

        // Reset in the middle of a 24-bit frame
        pulse_frame(8'h0A, 32'hC001E801);
        repeat (100) step();
        check("mid_busy", 32'(s_axis_tready), 32'd0);
        areset = 1'b1;
        step();
        check("mid_rst_cs",     32'(cs), 32'hF);
        check("mid_rst_sclk",   32'(sclk), 32'd0);
        check("mid_rst_sdi",    32'(sdi), 32'd0);
        check("mid_rst_tready", 32'(s_axis_tready), 32'd1);
        areset = 1'b0;
        repeat (3) step();
        base = frames_done;
        pulse_frame(8'h0A, 32'h5A3C9600);
        wait_frames("post_rst_timeout", base + 1, 400);
        check("post_rst_bits",   last_bits, 32'h005A3C96);
        check("post_rst_pulses", 32'(last_pulses), 32'd24);
        check("post_rst_cs",     32'(last_cs), 32'hB);
        wait_ready("post_rst_ready_timeout", 50);

        // Inputs changed while busy must not disturb the frame
        base = frames_done;
        pulse_frame(8'h05, 32'h3C5A0000);
        repeat (5) step();
        cmd = 8'h0E; s_axis_tdata = 32'hFFFFFFFF;
        repeat (40) step();
        cmd = 8'h00; s_axis_tdata = 32'h00000000;
        wait_frames("chg_timeout", base + 1, 300);
        check("chg_bits",   last_bits, 32'h00003C5A);
        check("chg_pulses", 32'(last_pulses), 32'd16);
        check("chg_cs_low", 32'(last_cs_low), 32'd132);
        check("chg_cs",     32'(last_cs), 32'hD);
        wait_ready("chg_ready_timeout", 50);

        check("pin_invariants", 32'(inv_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
